avalon_bus_arbiter: RTL and testbench

AVALON_BUS_ARBITER -- requirements
Module: avalon_bus_arbiter

---
 rtl/avalon_bus_arbiter_if.sv | 20 ++
 rtl/avalon_bus_arbiter.sv | 122 ++++++++++++
 tb/tb_avalon_bus_arbiter.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/avalon_bus_arbiter_if.sv
// rtl/avalon_bus_arbiter_if.sv - Avalon-MM port bundle with master and slave views
interface avalon_bus_arbiter_if;
  logic        read;
  logic        write;
  logic [31:0] address;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        waitrequest;

  modport master (
    output read, write, address, writedata, byteenable,
    input  readdata, waitrequest
  );

  modport slave (
    input  read, write, address, writedata, byteenable,
    output readdata, waitrequest
  );
endinterface

// File: rtl/avalon_bus_arbiter.sv
// rtl/avalon_bus_arbiter.sv - two-master fair arbiter onto one Avalon-MM slave with watchdog
module avalon_bus_arbiter #(
  parameter int MAX_WAIT = 255
) (
  input  logic                        clk,
  input  logic                        reset,
  avalon_bus_arbiter_if.slave         m0,
  avalon_bus_arbiter_if.slave         m1,
  avalon_bus_arbiter_if.master        s,
  output logic [1:0]                  grant,
  output logic                        bus_error
);

  localparam int CW = ($clog2(MAX_WAIT + 1) > 8) ? $clog2(MAX_WAIT + 1) : 8;
  localparam logic [CW:0] LIMIT = (CW + 1)'(MAX_WAIT);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t          state;
  state_t          next_state;
  logic            last_owner;
  logic [CW-1:0]   wait_cnt;
  logic            req0;
  logic            req1;
  logic            owner_req;
  logic            done;
  logic            timeout;

  assign req0      = m0.read | m0.write;
  assign req1      = m1.read | m1.write;
  assign owner_req = (state == OWN0) ? req0 : (state == OWN1) ? req1 : 1'b0;
  assign done      = owner_req & ~s.waitrequest;
  // Fires on the last permitted wait cycle so the owner sees at most MAX_WAIT of them.
  assign timeout   = owner_req & s.waitrequest &
                     (({1'b0, wait_cnt} + (CW + 1)'(1)) >= LIMIT);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_owner)) begin
          next_state = OWN0;
        end else if (req1) begin
          next_state = OWN1;
        end
      end
      OWN0, OWN1: begin
        if (!owner_req || done || timeout) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Counter is held at zero in IDLE, which clears it on every fresh grant.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_owner <= 1'b1;
      wait_cnt   <= '0;
      bus_error  <= 1'b0;
    end else begin
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (s.waitrequest && (wait_cnt != {CW{1'b1}})) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (done || timeout) begin
        last_owner <= (state == OWN1);
      end
      if (timeout) begin
        bus_error <= 1'b1;
      end
    end
  end

  always_comb begin
    s.read         = 1'b0;
    s.write        = 1'b0;
    s.address      = '0;
    s.writedata    = '0;
    s.byteenable   = '0;
    m0.waitrequest = 1'b1;
    m1.waitrequest = 1'b1;
    grant          = 2'b00;
    if (!reset) begin
      case (state)
        OWN0: begin
          s.read         = m0.read;
          s.write        = m0.write & ~m0.read;
          s.address      = m0.address;
          s.writedata    = m0.writedata;
          s.byteenable   = m0.byteenable;
          m0.waitrequest = s.waitrequest;
          grant          = 2'b01;
        end
        OWN1: begin
          s.read         = m1.read;
          s.write        = m1.write & ~m1.read;
          s.address      = m1.address;
          s.writedata    = m1.writedata;
          s.byteenable   = m1.byteenable;
          m1.waitrequest = s.waitrequest;
          grant          = 2'b10;
        end
        default: ;
      endcase
    end
  end

  assign m0.readdata = s.readdata;
  assign m1.readdata = s.readdata;

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// tb/tb_avalon_bus_arbiter.sv - scoreboard bench for avalon_bus_arbiter
module tb_avalon_bus_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] grant;
  logic       bus_error;

  avalon_bus_arbiter_if m0 ();
  avalon_bus_arbiter_if m1 ();
  avalon_bus_arbiter_if s ();

  avalon_bus_arbiter #(.MAX_WAIT(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0        (m0),
    .m1        (m1),
    .s         (s),
    .grant     (grant),
    .bus_error (bus_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          m;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Slave: waits slv_wait cycles per transfer, or forever while slv_stuck.
  int unsigned slv_wait  = 0;
  bit          slv_stuck = 1'b0;
  logic [31:0] slv_rdata = '0;
  int unsigned wcnt      = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) wcnt <= 0;
    else if ((s.read || s.write) && s.waitrequest) wcnt <= wcnt + 1;
    else wcnt <= 0;
  end
  assign s.waitrequest = slv_stuck || (wcnt < slv_wait);
  assign s.readdata    = slv_rdata;

  logic [1:0]  g_tr[32];
  logic [31:0] sa_tr[32];
  logic [31:0] sd_tr[32];
  logic [3:0]  sbe_tr[32];
  logic        sw_tr[32];
  logic        w0_tr[32];
  logic        w1_tr[32];
  logic        err_tr[32];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic drive(input int m, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be);
    if (m == 0) begin
      m0.read = rd; m0.write = wr; m0.address = a; m0.writedata = d; m0.byteenable = be;
    end else begin
      m1.read = rd; m1.write = wr; m1.address = a; m1.writedata = d; m1.byteenable = be;
    end
  endtask

  function automatic logic m_wait(input int m);
    return (m == 0) ? m0.waitrequest : m1.waitrequest;
  endfunction

  task automatic xfer(input int m, input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit hold);
    int cyc = 0;
    drive(m, !wr, wr, a, d, be);
    @(negedge clk);
    while (m_wait(m)) begin
      cyc++;
      if (cyc > 100) begin
        chk($sformatf("xfer_timeout_m%0d", m), 32'd1, 32'd0);
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    if (!hold) drive(m, 1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic record(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      g_tr[i] = grant;      sa_tr[i] = s.address;  sd_tr[i] = s.writedata;
      sbe_tr[i] = s.byteenable; sw_tr[i] = s.write;
      w0_tr[i] = m0.waitrequest; w1_tr[i] = m1.waitrequest; err_tr[i] = bus_error;
    end
  endtask

  // Expected grant trace: '1' = master 0, '2' = master 1, '0' = idle.
  task automatic chk_gtrace(input string tag, input string exp);
    for (int i = 0; i < exp.len(); i++) begin
      logic [1:0] eg;
      eg = (exp[i] == "1") ? 2'b01 : (exp[i] == "2") ? 2'b10 : 2'b00;
      chk($sformatf("%s_grant[%0d]", tag, i), 32'(g_tr[i]), 32'(eg));
    end
  endtask

  task automatic check_done(input int m);
    exp_t e;
    if (sb.size() == 0) begin
      chk($sformatf("unexpected_done_m%0d", m), 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("done_master", 32'(m), 32'(e.m));
    chk("done_addr", s.address, e.addr);
    if (e.wr) begin
      chk("done_s_write", 32'(s.write), 32'd1);
      chk("done_wdata", s.writedata, e.data);
      chk("done_be", 32'(s.byteenable), 32'(e.be));
    end else begin
      chk("done_s_read", 32'(s.read), 32'd1);
      chk("done_s_write_low", 32'(s.write), 32'd0);
      chk("done_rdata", (m == 0) ? m0.readdata : m1.readdata, e.data);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (m0.waitrequest === 1'b0 && (m0.read || m0.write)) check_done(0);
      if (m1.waitrequest === 1'b0 && (m1.read || m1.write)) check_done(1);
      if (m0.waitrequest === 1'b0 && m1.waitrequest === 1'b0)
        chk("both_released", 32'd1, 32'd0);
    end
  end

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state, checked before the first clock edge
    reset = 1'b1;
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    #3;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_bus_error", 32'(bus_error), 32'd0);
    chk("rst_s_read", 32'(s.read), 32'd0);
    chk("rst_s_write", 32'(s.write), 32'd0);
    chk("rst_s_address", s.address, 32'd0);
    chk("rst_m0_wait", 32'(m0.waitrequest), 32'd1);
    chk("rst_m1_wait", 32'(m1.waitrequest), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Master 0 read, three slave wait cycles
    slv_wait = 3; slv_rdata = 32'h2402_0005;
    sb.push_back('{0, 1'b0, 32'hBFC0_0000, 32'h2402_0005, 4'hF});
    @(negedge clk); #1;
    fork
      xfer(0, 1'b0, 32'hBFC0_0000, '0, 4'hF, 1'b0);
      record(6);
    join
    chk_gtrace("t1", "111100");
    for (int i = 0; i < 6; i++) chk($sformatf("t1_m1_wait[%0d]", i), 32'(w1_tr[i]), 32'd1);

    // Simultaneous reads after reset: master 0 first
    do_reset();
    slv_wait = 0; slv_rdata = 32'h0000_A5A5;
    sb.push_back('{0, 1'b0, 32'h0000_0100, 32'h0000_A5A5, 4'hF});
    sb.push_back('{1, 1'b0, 32'h0000_0200, 32'h0000_A5A5, 4'hF});
    @(negedge clk); #1;
    fork
      xfer(0, 1'b0, 32'h0000_0100, '0, 4'hF, 1'b0);
      xfer(1, 1'b0, 32'h0000_0200, '0, 4'hF, 1'b0);
      record(5);
    join
    chk_gtrace("t2", "10200");
    chk("t2_addr0", sa_tr[0], 32'h0000_0100);
    chk("t2_addr1", sa_tr[1], 32'h0000_0000);
    chk("t2_addr2", sa_tr[2], 32'h0000_0200);

    // Master 1 write with four waits while master 0 is held off
    slv_wait = 4; slv_rdata = 32'hCAFE_0003;
    sb.push_back('{1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011});
    sb.push_back('{0, 1'b0, 32'h0000_0300, 32'hCAFE_0003, 4'hF});
    @(negedge clk); #1;
    fork
      xfer(1, 1'b1, 32'h0000_1000, 32'hDEAD_BEEF, 4'b0011, 1'b0);
      begin @(negedge clk); #1; xfer(0, 1'b0, 32'h0000_0300, '0, 4'hF, 1'b0); end
      record(12);
    join
    chk_gtrace("t3", "222220111110");
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3_s_write[%0d]", i), 32'(sw_tr[i]), 32'd1);
      chk($sformatf("t3_wdata[%0d]", i), sd_tr[i], 32'hDEAD_BEEF);
      chk($sformatf("t3_be[%0d]", i), 32'(sbe_tr[i]), 32'b0011);
      chk($sformatf("t3_m0_wait[%0d]", i), 32'(w0_tr[i]), 32'd1);
    end

    // Watchdog: slave never releases waitrequest (MAX_WAIT = 8)
    slv_stuck = 1'b1;
    @(negedge clk); #1;
    drive(0, 1'b1, 1'b0, 32'h0000_0400, '0, 4'hF);
    record(9);
    drive(0, 1'b0, 1'b0, '0, '0, '0);
    chk_gtrace("t4", "111111110");
    chk("t4_err_before", 32'(err_tr[7]), 32'd0);
    chk("t4_err_after", 32'(err_tr[8]), 32'd1);
    slv_stuck = 1'b0; slv_wait = 1; slv_rdata = 32'h5555_0001;
    sb.push_back('{1, 1'b0, 32'h0000_0500, 32'h5555_0001, 4'hF});
    @(negedge clk); #1;
    xfer(1, 1'b0, 32'h0000_0500, '0, 4'hF, 1'b0);
    chk("t4_err_sticky", 32'(bus_error), 32'd1);

    // Reset pulsed mid OWN1 write
    slv_wait = 4;
    @(negedge clk); #1;
    drive(1, 1'b0, 1'b1, 32'h0000_2000, 32'h1234_5678, 4'hF);
    @(negedge clk);
    chk("t5_grant_own1", 32'(grant), 32'b10);
    chk("t5_s_write_pre", 32'(s.write), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("t5_s_write_rst", 32'(s.write), 32'd0);
    chk("t5_s_read_rst", 32'(s.read), 32'd0);
    chk("t5_m1_wait_rst", 32'(m1.waitrequest), 32'd1);
    chk("t5_grant_rst", 32'(grant), 32'd0);
    drive(1, 1'b0, 1'b0, '0, '0, '0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("t5_grant_post", 32'(grant), 32'd0);
    chk("t5_err_post", 32'(bus_error), 32'd0);
    record(2);
    chk_gtrace("t5", "00");

    // Master 0 streams three reads, master 1 asks once: no starvation
    slv_wait = 0; slv_rdata = 32'h0000_0077;
    sb.push_back('{0, 1'b0, 32'h0000_0600, 32'h0000_0077, 4'hF});
    sb.push_back('{1, 1'b0, 32'h0000_0700, 32'h0000_0077, 4'hF});
    sb.push_back('{0, 1'b0, 32'h0000_0604, 32'h0000_0077, 4'hF});
    sb.push_back('{0, 1'b0, 32'h0000_0608, 32'h0000_0077, 4'hF});
    @(negedge clk); #1;
    fork
      begin
        xfer(0, 1'b0, 32'h0000_0600, '0, 4'hF, 1'b1);
        xfer(0, 1'b0, 32'h0000_0604, '0, 4'hF, 1'b1);
        xfer(0, 1'b0, 32'h0000_0608, '0, 4'hF, 1'b0);
      end
      xfer(1, 1'b0, 32'h0000_0700, '0, 4'hF, 1'b0);
      record(8);
    join
    chk_gtrace("t6", "10201010");
    chk("t6_addr2", sa_tr[2], 32'h0000_0700);
    chk("t6_addr4", sa_tr[4], 32'h0000_0604);
    chk("t6_addr6", sa_tr[6], 32'h0000_0608);

    @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
